data_mem_responder: RTL

- Data-memory responder at the far end of the pipeline memory-stage request interface; the control unit's memEn/memRW/load-store decode drives the initiator side.
- Accepts one load or store at a time, word or byte size, and holds it for WAIT_STATES cycles to model SRAM latency.
- Commits the access to an internal byte-addressed array, then returns data or an error through a valid/ready response handshake.
- Pipeline stalls on busy.

---
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/data_mem_responder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Memory-stage request/response bus between the pipeline (master) and the data memory (slave).
interface data_mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic              req_byte;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_rw, req_byte, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_rw, req_byte, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one word/byte load or store at a time, WAIT_STATES latency,
// byte-addressed little-endian array, valid/ready response with error flag.
module data_mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus,
    output logic                 busy
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              lat_rw, lat_byte;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic              accept, commit;
    logic              c_rw, c_byte, c_err;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata, c_word, c_lanes, c_rdata;
    logic [IDX_W-1:0]  c_idx;

    assign bus.req_ready  = (state == IDLE) && rst_n;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign busy           = (state != IDLE);
    assign accept         = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        commit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(WAIT_STATES)) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the commit happens on the accepting edge, so use the live request.
    always_comb begin
        if (state == IDLE) begin
            c_rw    = bus.req_rw;
            c_byte  = bus.req_byte;
            c_addr  = bus.req_addr;
            c_wdata = bus.req_wdata;
        end else begin
            c_rw    = lat_rw;
            c_byte  = lat_byte;
            c_addr  = lat_addr;
            c_wdata = lat_wdata;
        end
        c_err   = (!c_byte && (c_addr[1:0] != 2'b00)) || ({1'b0, c_addr} >= ADDR_LIMIT);
        c_idx   = c_addr[IDX_W+1:2];
        c_word  = mem[c_idx];
        c_lanes = c_byte ? {4{c_wdata[7:0]}} : c_wdata;
        c_rdata = '0;
        if (!c_err && !c_rw) begin
            c_rdata = c_byte ? DATA_W'(c_word[{c_addr[1:0], 3'b000} +: 8]) : c_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_rw    <= 1'b0;
            lat_byte  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                lat_rw    <= bus.req_rw;
                lat_byte  <= bus.req_byte;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
            end
            if (commit) begin
                rdata_q <= c_rdata;
                err_q   <= c_err;
            end
        end
    end

    // Array keeps its contents through reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst_n && commit && c_rw && !c_err) begin
            for (int unsigned l = 0; l < 4; l++) begin
                if (!c_byte || (c_addr[1:0] == l[1:0])) begin
                    mem[c_idx][8*l +: 8] <= c_lanes[8*l +: 8];
                end
            end
        end
    end
endmodule
